// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg -- shared pipeline definitions for the hazard controller.
//   FWD_RF / FWD_W / FWD_M : ALU operand source encodings (register file, W, M)
//   RESULT_SRC_LOAD        : resultSrcE value that marks a load in execute
//   state_t                : memory-wait FSM states {RUN, WAIT}
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// fwd_unit -- operand forwarding select for one execute-stage source register.
//   rs        in  5 : execute-stage source register number
//   regWriteM in  1 : memory stage will write RdM
//   RdM       in  5 : memory-stage destination
//   regWriteW in  1 : writeback stage will write RdW
//   RdW       in  5 : writeback-stage destination
//   forward   out 2 : FWD_M, FWD_W or FWD_RF
module fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       regWriteM,
    input  logic [4:0] RdM,
    input  logic       regWriteW,
    input  logic [4:0] RdW,
    output logic [1:0] forward
);

    // M is the younger producer, so it is checked first; x0 never forwards.
    always_comb begin
        if (regWriteM && (RdM != 5'd0) && (RdM == rs))
            forward = FWD_M;
        else if (regWriteW && (RdW != 5'd0) && (RdW == rs))
            forward = FWD_W;
        else
            forward = FWD_RF;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard unit: forwarding, load-use stall, branch
// flush and data-memory wait handling with a sticky timeout flag.
//   clk, rst (async, active-low)
//   Rs1D/Rs2D, Rs1E/Rs2E/RdE, resultSrcE, PCSrcE : decode/execute info
//   regWriteM/RdM, regWriteW/RdW                 : writeback intent for forwarding
//   memReqM, memReadyM                           : data memory handshake
//   stallF/D/E/M, flushD, flushE                 : pipeline register control
//   forwardAE/BE                                 : ALU operand source selects
//   memErr                                       : sticky memory-wait timeout
// Optional: define HAZARD_PERF_CNT_EN to add the saturating 32-bit
// stallCycles / flushCycles performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [1:0]  resultSrcE,
    input  logic        PCSrcE,
    input  logic        regWriteM,
    input  logic [4:0]  RdM,
    input  logic        regWriteW,
    input  logic [4:0]  RdW,
    input  logic        memReqM,
    input  logic        memReadyM,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        stallM,
    output logic        flushD,
    output logic        flushE,
    output logic [1:0]  forwardAE,
    output logic [1:0]  forwardBE,
    output logic        memErr
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stallCycles,
    output logic [31:0] flushCycles
`endif
);

    localparam int             CNT_W   = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] waitCnt;
    logic             lwStall;
    logic             memWait;
    logic [1:0]       fwdA;
    logic [1:0]       fwdB;

    fwd_unit u_fwd_a (
        .rs        (Rs1E),
        .regWriteM (regWriteM),
        .RdM       (RdM),
        .regWriteW (regWriteW),
        .RdW       (RdW),
        .forward   (fwdA)
    );

    fwd_unit u_fwd_b (
        .rs        (Rs2E),
        .regWriteM (regWriteM),
        .RdM       (RdM),
        .regWriteW (regWriteW),
        .RdW       (RdW),
        .forward   (fwdB)
    );

    // Forward selects read as register-file while reset is held.
    assign forwardAE = rst ? fwdA : FWD_RF;
    assign forwardBE = rst ? fwdB : FWD_RF;

    assign lwStall = (resultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));

    // Once waiting, the request is already committed; only ready ends it.
    assign memWait = (state == RUN) ? (memReqM && !memReadyM) : !memReadyM;

    // NOTE: every output gets a default at the top of the block so no path
    // leaves it unassigned, which is what keeps this from inferring latches.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b1;
        flushE = 1'b1;
        if (rst) begin
            if (memWait) begin
                // Freeze everything; a pending flush waits because the EX
                // inputs that requested it are held stable too.
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushD = 1'b0;
                flushE = 1'b0;
            end else begin
                stallF = lwStall;
                stallD = lwStall;
                flushD = PCSrcE;
                flushE = lwStall || PCSrcE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            waitCnt <= '0;
            memErr  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (memWait) begin
                        state   <= WAIT;
                        waitCnt <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (waitCnt == CNT_MAX)
                        memErr <= 1'b1;
                    if (memReadyM) begin
                        state   <= RUN;
                        waitCnt <= '0;
                    end else if (waitCnt != CNT_MAX) begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= RUN;
                    waitCnt <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCycles <= '0;
            flushCycles <= '0;
        end else begin
            if (stallF && (stallCycles != 32'hFFFF_FFFF))
                stallCycles <= stallCycles + 32'd1;
            if (flushE && (flushCycles != 32'hFFFF_FFFF))
                flushCycles <= flushCycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- directed self-checking bench for hazard_ctrl.
// Runs the DUT with WAIT_TIMEOUT = 4 so the timeout path is reachable quickly.
// Inputs change just after a falling edge; outputs are checked 1 ns later.
// Define HAZARD_PERF_CNT_EN to also exercise the performance counters.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] resultSrcE;
    logic       PCSrcE, regWriteM, regWriteW, memReqM, memReadyM;
    logic       stallF, stallD, stallE, stallM, flushD, flushE;
    logic [1:0] forwardAE, forwardBE;
    logic       memErr;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stallCycles, flushCycles;
`endif

    int checks = 0;
    int errors = 0;

    // {stallF, stallD, stallE, stallM, flushD, flushE}
    logic [5:0] ctrl;
    assign ctrl = {stallF, stallD, stallE, stallM, flushD, flushE};

    always #5 clk = ~clk;

    hazard_ctrl #(.WAIT_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .resultSrcE (resultSrcE),
        .PCSrcE     (PCSrcE),
        .regWriteM  (regWriteM),
        .RdM        (RdM),
        .regWriteW  (regWriteW),
        .RdW        (RdW),
        .memReqM    (memReqM),
        .memReadyM  (memReadyM),
        .stallF     (stallF),
        .stallD     (stallD),
        .stallE     (stallE),
        .stallM     (stallM),
        .flushD     (flushD),
        .flushE     (flushE),
        .forwardAE  (forwardAE),
        .forwardBE  (forwardBE),
        .memErr     (memErr)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stallCycles(stallCycles),
        .flushCycles(flushCycles)
`endif
    );

    task automatic set_idle();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0;
        RdM = 5'd0; RdW = 5'd0; resultSrcE = 2'b00; PCSrcE = 1'b0;
        regWriteM = 1'b0; regWriteW = 1'b0; memReqM = 1'b0; memReadyM = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        // Inputs that would otherwise forward and stall must be masked.
        regWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5; Rs2E = 5'd5;
        memReqM = 1'b1;
        #1;
        checks++;
        if (ctrl !== 6'b000011) begin
            errors++;
            $display("FAIL reset_ctrl got %b want %b", ctrl, 6'b000011);
        end
        checks++;
        if ({forwardAE, forwardBE} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_fwd got %b%b want 0000", forwardAE, forwardBE);
        end
        checks++;
        if (memErr !== 1'b0) begin
            errors++;
            $display("FAIL reset_memerr got %b want 0", memErr);
        end
        @(negedge clk);
        set_idle();
        rst = 1'b1;
        #1;
        checks++;
        if (ctrl !== 6'b000000) begin
            errors++;
            $display("FAIL post_reset_ctrl got %b want %b", ctrl, 6'b000000);
        end
    endtask

    task automatic test_forward();
        // {regWriteM, RdM, regWriteW, RdW, Rs1E, Rs2E, expA, expB}
        logic [29:0] vec [6];
        vec[0] = {1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 5'd6, 2'b10, 2'b00};
        vec[1] = {1'b1, 5'd0, 1'b1, 5'd5, 5'd5, 5'd0, 2'b01, 2'b00};
        vec[2] = {1'b0, 5'd5, 1'b1, 5'd3, 5'd5, 5'd3, 2'b00, 2'b01};
        vec[3] = {1'b1, 5'd9, 1'b0, 5'd9, 5'd1, 5'd9, 2'b00, 2'b10};
        vec[4] = {1'b1, 5'd4, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00};
        vec[5] = {1'b1, 5'd7, 1'b1, 5'd8, 5'd8, 5'd7, 2'b01, 2'b10};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_idle();
            {regWriteM, RdM, regWriteW, RdW, Rs1E, Rs2E} = vec[i][29:4];
            #1;
            checks++;
            if ({forwardAE, forwardBE} !== vec[i][3:0]) begin
                errors++;
                $display("FAIL fwd_vec%0d got %b%b want %b", i, forwardAE, forwardBE, vec[i][3:0]);
            end
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        set_idle();
        resultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        #1;
        checks++;
        if (ctrl !== 6'b110001) begin
            errors++;
            $display("FAIL lw_stall got %b want %b", ctrl, 6'b110001);
        end
        // Bubble now sits in EX: the load has moved on.
        @(negedge clk);
        set_idle();
        Rs2D = 5'd7;
        #1;
        checks++;
        if (ctrl !== 6'b000000) begin
            errors++;
            $display("FAIL lw_after got %b want %b", ctrl, 6'b000000);
        end
        @(negedge clk);
        set_idle();
        resultSrcE = 2'b01; RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
        #1;
        checks++;
        if (ctrl !== 6'b000000) begin
            errors++;
            $display("FAIL lw_rd0 got %b want %b", ctrl, 6'b000000);
        end
        @(negedge clk);
        set_idle();
        resultSrcE = 2'b10; RdE = 5'd3; Rs1D = 5'd3;
        #1;
        checks++;
        if (ctrl !== 6'b000000) begin
            errors++;
            $display("FAIL lw_notload got %b want %b", ctrl, 6'b000000);
        end
        @(negedge clk);
        set_idle();
        resultSrcE = 2'b01; RdE = 5'd3; Rs1D = 5'd3;
        #1;
        checks++;
        if (ctrl !== 6'b110001) begin
            errors++;
            $display("FAIL lw_rs1 got %b want %b", ctrl, 6'b110001);
        end
    endtask

    task automatic test_branch();
        @(negedge clk);
        set_idle();
        PCSrcE = 1'b1;
        #1;
        checks++;
        if (ctrl !== 6'b000011) begin
            errors++;
            $display("FAIL branch got %b want %b", ctrl, 6'b000011);
        end
        @(negedge clk);
        set_idle();
        PCSrcE = 1'b1; resultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        #1;
        checks++;
        if (ctrl !== 6'b110011) begin
            errors++;
            $display("FAIL branch_lw got %b want %b", ctrl, 6'b110011);
        end
    endtask

    task automatic test_mem_wait();
        @(negedge clk);
        set_idle();
        memReqM = 1'b1; memReadyM = 1'b1;
        #1;
        checks++;
        if (ctrl !== 6'b000000) begin
            errors++;
            $display("FAIL mem_ready_now got %b want %b", ctrl, 6'b000000);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_idle();
            memReqM = 1'b1; PCSrcE = 1'b1;
            #1;
            checks++;
            if (ctrl !== 6'b111100) begin
                errors++;
                $display("FAIL mem_wait_cyc%0d got %b want %b", i, ctrl, 6'b111100);
            end
        end
        @(negedge clk);
        memReadyM = 1'b1;
        #1;
        checks++;
        if (ctrl !== 6'b000011) begin
            errors++;
            $display("FAIL mem_release got %b want %b", ctrl, 6'b000011);
        end
        // Back in RUN: no request means no stall even with ready low.
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if ({ctrl, memErr} !== 7'b0000000) begin
            errors++;
            $display("FAIL mem_run got %b want %b", {ctrl, memErr}, 7'b0000000);
        end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        set_idle();
        memReqM = 1'b1;
        #1;
        checks++;
        if ({ctrl, memErr} !== 7'b1111000) begin
            errors++;
            $display("FAIL to_enter got %b want %b", {ctrl, memErr}, 7'b1111000);
        end
        // WAIT cycles 1..4: still waiting even with the request dropped.
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            memReqM = 1'b0;
            #1;
            checks++;
            if ({ctrl, memErr} !== 7'b1111000) begin
                errors++;
                $display("FAIL to_wait%0d got %b want %b", i, {ctrl, memErr}, 7'b1111000);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if ({ctrl, memErr} !== 7'b1111001) begin
            errors++;
            $display("FAIL to_err got %b want %b", {ctrl, memErr}, 7'b1111001);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({ctrl, memErr} !== 7'b1111001) begin
            errors++;
            $display("FAIL to_sticky got %b want %b", {ctrl, memErr}, 7'b1111001);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({ctrl, memErr} !== 7'b0000110) begin
            errors++;
            $display("FAIL to_rst got %b want %b", {ctrl, memErr}, 7'b0000110);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({ctrl, memErr} !== 7'b0000000) begin
            errors++;
            $display("FAIL to_after_rst got %b want %b", {ctrl, memErr}, 7'b0000000);
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf();
        @(negedge clk);
        set_idle();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({stallCycles, flushCycles} !== 64'd0) begin
            errors++;
            $display("FAIL perf_reset got %0d/%0d want 0/0", stallCycles, flushCycles);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            resultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
            @(negedge clk);
            set_idle();
        end
        #1;
        checks++;
        if (stallCycles !== 32'd10) begin
            errors++;
            $display("FAIL perf_stall got %0d want 10", stallCycles);
        end
        checks++;
        if (flushCycles !== 32'd10) begin
            errors++;
            $display("FAIL perf_flush got %0d want 10", flushCycles);
        end
    endtask
`endif

    initial begin
        set_idle();
        rst = 1'b1;
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
`ifdef HAZARD_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
